// File: rtl/fifo_sync_wm.sv
// fifo_sync_wm: synchronous FIFO with watermark flags, full/empty status,
// sticky overflow-attempt flag and optional peak-occupancy tracker.
// Optional feature macro: FIFO_SYNC_WM_PEAK_EN (peak_o register; tied to 0
// when undefined).
// Pointers carry a wrap bit above the index, so any Depth >= 1 works.
module fifo_sync_wm #(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 4,
  parameter bit          Pass              = 1'b1,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned DepthW           = (Depth < 1) ? 1 : $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [DepthW-1:0] afull_thresh_i,
  input  logic [DepthW-1:0] aempty_thresh_i,
  output logic              afull_o,
  output logic              aempty_o,
  output logic              ovf_o,
  output logic [DepthW-1:0] peak_o
);

  localparam int unsigned     PtrW    = (Depth <= 1) ? 1 : $clog2(Depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  if (Depth < 1) begin : g_bad_depth
    $error("fifo_sync_wm: Depth must be at least 1");
  end

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW:0]     wptr_q, wptr_d;
  logic [PtrW:0]     rptr_q, rptr_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;

  logic full, empty;
  logic pass_xfer, wr_en, rd_en;

  // Advance a pointer, wrapping the index at Depth-1 and toggling the wrap bit.
  function automatic logic [PtrW:0] ptr_inc(input logic [PtrW:0] p);
    logic [PtrW:0] r;
    if (p[PtrW-1:0] == LastIdx) begin
      r = {~p[PtrW], {PtrW{1'b0}}};
    end else begin
      r = {p[PtrW], p[PtrW-1:0] + PtrW'(1)};
    end
    return r;
  endfunction

  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // A pass-through transfer bypasses storage entirely.
  assign pass_xfer = Pass && empty && wvalid_i && rready_i;
  assign wr_en     = wvalid_i && !full && !pass_xfer;
  assign rd_en     = rready_i && !empty;

  // Pointer next-state; clear wins over any handshake.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = ptr_inc(wptr_q);
      if (rd_en) rptr_d = ptr_inc(rptr_q);
    end
  end

  // Occupancy counter next-state: moves only when exactly one side transfers.
  always_comb begin
    depth_d = depth_q;
    if (clr_i) begin
      depth_d = '0;
    end else if (wr_en && !rd_en) begin
      depth_d = depth_q + DepthW'(1);
    end else if (rd_en && !wr_en) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  // Sticky overflow: a write presented while full that no read is draining.
  // With a same-cycle read the write is merely held off by wready_o.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
    end else if (wvalid_i && full && !rready_i) begin
      ovf_d = 1'b1;
    end
  end

  // Pointer, counter and overflow state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk_i) begin
    if (wr_en && !clr_i) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

`ifdef FIFO_SYNC_WM_PEAK_EN
  logic [DepthW-1:0] peak_q, peak_d;

  // Peak tracks the largest occupancy the counter is about to hold.
  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = '0;
    end else if (depth_d > peak_q) begin
      peak_d = depth_d;
    end
  end

  // Peak register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

  // Read data: head entry, else pass-through write data, else zero/head.
  always_comb begin
    rdata_o = OutputZeroIfEmpty ? '0 : mem_q[rptr_q[PtrW-1:0]];
    if (!empty) begin
      rdata_o = mem_q[rptr_q[PtrW-1:0]];
    end else if (Pass && wvalid_i) begin
      rdata_o = wdata_i;
    end
  end

  assign rvalid_o = Pass ? (!empty || wvalid_i) : !empty;
  assign wready_o = !full;
  assign full_o   = full;
  assign empty_o  = empty;
  assign depth_o  = depth_q;
  assign afull_o  = (depth_q >= afull_thresh_i);
  assign aempty_o = (depth_q <= aempty_thresh_i);
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_fifo_sync_wm.sv
// Bench for fifo_sync_wm: instance a (Depth=4, Pass=0), instance b (Depth=3,
// Pass=1). Expected read data is queued at stimulus time and checked by an
// independent monitor whenever a read handshake is seen.
module tb_fifo_sync_wm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  // instance a
  logic        a_clr = 0, a_wvalid = 0, a_rready = 0;
  logic [15:0] a_wdata = '0;
  logic        a_wready, a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf;
  logic [15:0] a_rdata;
  logic [2:0]  a_depth, a_peak;
  logic [2:0]  a_afth = 3'd3, a_aeth = 3'd1;

  // instance b
  logic        b_clr = 0, b_wvalid = 0, b_rready = 0;
  logic [15:0] b_wdata = '0;
  logic        b_wready, b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf;
  logic [15:0] b_rdata;
  logic [1:0]  b_depth, b_peak;
  logic [1:0]  b_afth = 2'd2, b_aeth = 2'd0;

  fifo_sync_wm #(.Width(16), .Depth(4), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr),
    .wvalid_i(a_wvalid), .wready_o(a_wready), .wdata_i(a_wdata),
    .rvalid_o(a_rvalid), .rready_i(a_rready), .rdata_o(a_rdata),
    .depth_o(a_depth), .full_o(a_full), .empty_o(a_empty),
    .afull_thresh_i(a_afth), .aempty_thresh_i(a_aeth),
    .afull_o(a_afull), .aempty_o(a_aempty), .ovf_o(a_ovf), .peak_o(a_peak)
  );

  fifo_sync_wm #(.Width(16), .Depth(3), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr),
    .wvalid_i(b_wvalid), .wready_o(b_wready), .wdata_i(b_wdata),
    .rvalid_o(b_rvalid), .rready_i(b_rready), .rdata_o(b_rdata),
    .depth_o(b_depth), .full_o(b_full), .empty_o(b_empty),
    .afull_thresh_i(b_afth), .aempty_thresh_i(b_aeth),
    .afull_o(b_afull), .aempty_o(b_aempty), .ovf_o(b_ovf), .peak_o(b_peak)
  );

`ifdef FIFO_SYNC_WM_PEAK_EN
  localparam logic [2:0] APeakExp = 3'd4;
  localparam logic [1:0] BPeakExp = 2'd3;
`else
  localparam logic [2:0] APeakExp = 3'd0;
  localparam logic [1:0] BPeakExp = 2'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pop and compare on every read handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rvalid && a_rready) begin
        if (qa.size() == 0) chk("a_unexpected_read", {16'h0, a_rdata}, 32'hFFFF_FFFF);
        else chk("a_rdata", {16'h0, a_rdata}, {16'h0, qa.pop_front()});
      end
      if (b_rvalid && b_rready) begin
        if (qb.size() == 0) chk("b_unexpected_read", {16'h0, b_rdata}, 32'hFFFF_FFFF);
        else chk("b_rdata", {16'h0, b_rdata}, {16'h0, qb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    smp();
    chk("rst_wready", a_wready, 1);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_depth", a_depth, 0);
    chk("rst_full", a_full, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_peak", a_peak, 0);
    chk("rst_afull", a_afull, 0);
    chk("rst_aempty", a_aempty, 1);
    cyc(); cyc();
    rst_n = 1'b1;

    // instance a: fill four, watermark checks along the way
    for (int i = 0; i < 4; i++) begin
      cyc();
      a_wvalid = 1'b1;
      a_wdata  = 16'h00A1 + 16'(i);
      qa.push_back(a_wdata);
      smp();
      chk("a_fill_depth", a_depth, i);
      chk("a_fill_aempty", a_aempty, (i <= 1));
      chk("a_fill_afull", a_afull, (i >= 3));
    end
    // overflow attempt while full
    cyc();
    a_wdata = 16'hDEAD;
    smp();
    chk("a_full", a_full, 1);
    chk("a_wready_full", a_wready, 0);
    chk("a_depth_full", a_depth, 4);
    chk("a_ovf_before", a_ovf, 0);
    chk("a_afull_full", a_afull, 1);
    chk("a_aempty_full", a_aempty, 0);
    cyc();
    a_wvalid = 1'b0;
    smp();
    chk("a_ovf_set", a_ovf, 1);
    chk("a_depth_after_ovf", a_depth, 4);
    // drain four
    for (int i = 0; i < 4; i++) begin
      cyc();
      a_rready = 1'b1;
      smp();
      chk("a_drain_depth", a_depth, 4 - i);
    end
    cyc();
    a_rready = 1'b0;
    smp();
    chk("a_empty_after", a_empty, 1);
    chk("a_depth_after", a_depth, 0);
    chk("a_ovf_sticky", a_ovf, 1);
    chk("a_rvalid_empty", a_rvalid, 0);
    chk("a_rdata_zero", a_rdata, 0);
    chk("a_peak", a_peak, APeakExp);
    // clear with a coincident write
    cyc();
    a_clr = 1'b1; a_wvalid = 1'b1; a_wdata = 16'hBEEF;
    smp();
    cyc();
    a_clr = 1'b0; a_wvalid = 1'b0;
    smp();
    chk("a_clr_ovf", a_ovf, 0);
    chk("a_clr_depth", a_depth, 0);
    chk("a_clr_peak", a_peak, 0);
    chk("a_clr_empty", a_empty, 1);

    // instance b: pass-through
    cyc();
    b_wvalid = 1'b1; b_rready = 1'b1; b_wdata = 16'h55AA;
    qb.push_back(16'h55AA);
    smp();
    chk("b_pass_rvalid", b_rvalid, 1);
    chk("b_pass_rdata", b_rdata, 16'h55AA);
    chk("b_pass_empty", b_empty, 1);
    cyc();
    b_wvalid = 1'b0; b_rready = 1'b0;
    smp();
    chk("b_pass_depth", b_depth, 0);
    chk("b_pass_rvalid_after", b_rvalid, 0);

    // Depth=3 wrap: ten pairs with a one-entry lag
    for (int k = 0; k <= 10; k++) begin
      cyc();
      b_wvalid = (k < 10);
      b_rready = (k > 0);
      if (k < 10) begin
        b_wdata = 16'h3000 + 16'(k);
        qb.push_back(b_wdata);
      end
      smp();
      chk("b_wrap_depth", b_depth, (k == 0) ? 0 : 1);
    end
    cyc();
    b_wvalid = 1'b0; b_rready = 1'b0;
    smp();
    chk("b_wrap_end_depth", b_depth, 0);
    chk("b_wrap_end_empty", b_empty, 1);

    // fill to 3
    for (int i = 0; i < 3; i++) begin
      cyc();
      b_wvalid = 1'b1;
      b_wdata  = 16'h4000 + 16'(i);
      qb.push_back(b_wdata);
      smp();
      chk("b_fill_depth", b_depth, i);
    end
    cyc();
    b_wvalid = 1'b0;
    smp();
    chk("b_full", b_full, 1);
    chk("b_depth3", b_depth, 3);
    chk("b_afull", b_afull, 1);
    // simultaneous read and write while full: write held off, no overflow
    cyc();
    b_wvalid = 1'b1; b_rready = 1'b1; b_wdata = 16'h4FFF;
    smp();
    chk("b_wready_full", b_wready, 0);
    cyc();
    b_wvalid = 1'b0; b_rready = 1'b0;
    smp();
    chk("b_rw_full_depth", b_depth, 2);
    chk("b_rw_full_ovf", b_ovf, 0);
    chk("b_rw_full_full", b_full, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      b_rready = 1'b1;
      smp();
    end
    cyc();
    b_rready = 1'b0;
    smp();
    chk("b_drain_depth", b_depth, 0);
    chk("b_peak", b_peak, BPeakExp);

    // reset asserted mid-fill
    for (int i = 0; i < 2; i++) begin
      cyc();
      b_wvalid = 1'b1;
      b_wdata  = 16'h5000 + 16'(i);
      qb.push_back(b_wdata);
    end
    cyc();
    b_wvalid = 1'b0;
    rst_n = 1'b0;
    qb.delete();
    smp();
    chk("b_rst_depth", b_depth, 0);
    chk("b_rst_empty", b_empty, 1);
    chk("b_rst_rvalid", b_rvalid, 0);
    chk("b_rst_rdata", b_rdata, 0);
    chk("b_rst_full", b_full, 0);
    chk("b_rst_wready", b_wready, 1);
    chk("b_rst_ovf", b_ovf, 0);
    chk("b_rst_peak", b_peak, 0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    smp();
    chk("b_post_rst_rvalid", b_rvalid, 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
